// File: rtl/shared_dmem_arbiter_pkg.sv
// Shared constants and helpers for the N-port data memory arbiter.
package dmem_pkg;
  localparam int RSP_LAT  = 1;
  localparam int ADDR_MAX = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Word index from a byte address: drop the byte offset, wrap modulo depth.
  function automatic logic [ADDR_MAX-1:0] idx_of(input logic [ADDR_MAX-1:0] addr,
                                                 input int idx_w);
    return (addr >> 2) & ((ADDR_MAX'(1) << idx_w) - 1'b1);
  endfunction
endpackage

// File: rtl/shared_dmem_arbiter_if.sv
// Per-port request/response bundle between the CPU MEM stages and the shared memory.
interface shared_dmem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]             req_valid_i;
  logic [NUM_PORTS-1:0]             req_we_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]             req_ready_o;
  logic [NUM_PORTS-1:0]             rsp_valid_o;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata_o;

  modport master (output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
                  input  req_ready_o, rsp_valid_o, rsp_rdata_o);
  modport slave  (input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
                  output req_ready_o, rsp_valid_o, rsp_rdata_o);
endinterface

// File: rtl/shared_dmem_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins, pointer moves past it.
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);
  logic [PTR_W-1:0] ptr;
  logic             found;

  // Two passes: ports at/after ptr first, then the wrapped-around ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && i >= int'(ptr) && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    for (int i = 0; i < N; i++)
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PTR_W'(i);
      end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        ptr <= '0;
    else if (advance) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/shared_dmem_arbiter.sv
// N-port shared word memory: round-robin grant, one access per cycle, 1-cycle responses.
module shared_dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 128
) (
  input logic                  clk_i,
  input logic                  rst_i,
  shared_dmem_arbiter_if.slave bus
);
  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [NUM_PORTS-1:0]             req_m, gnt;
  logic [PTR_W-1:0]                 gnt_idx;
  logic                             fire;
  req_t                             sel;
  logic [IDX_W-1:0]                 idx;
  logic [DATA_W-1:0]                memory [DEPTH_WORDS];
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;

  logic [RSP_LAT:0]                 vld_pipe;
  logic [RSP_LAT:1]                 vld_q;
  logic [RSP_LAT:0][NUM_PORTS-1:0]  gnt_pipe;
  logic [RSP_LAT:1][NUM_PORTS-1:0]  gnt_q;

  assign req_m = bus.req_valid_i & {NUM_PORTS{~rst_i}};

  rr_arbiter #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_m),
    .advance (fire),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign fire            = |gnt;
  assign bus.req_ready_o = gnt;

  always_comb begin
    sel.we    = bus.req_we_i[gnt_idx];
    sel.addr  = bus.req_addr_i[gnt_idx];
    sel.wdata = bus.req_wdata_i[gnt_idx];
  end

  assign idx = IDX_W'(idx_of(ADDR_MAX'(sel.addr), IDX_W));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) memory[i] <= '0;
    end else if (fire && sel.we) begin
      memory[idx] <= sel.wdata;
    end
  end

  // Read data is captured at the accepting edge, so it sees only earlier writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (fire && !sel.we) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt[p]) rdata_q[p] <= memory[idx];
    end
  end

  assign vld_pipe = {vld_q, fire};
  assign gnt_pipe = {gnt_q, gnt};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      gnt_q <= '0;
    end else begin
      vld_q <= vld_pipe[RSP_LAT-1:0];
      gnt_q <= gnt_pipe[RSP_LAT-1:0];
    end
  end

  // A pulse still in flight when reset arrives is suppressed immediately.
  assign bus.rsp_valid_o = (vld_pipe[RSP_LAT] && !rst_i) ? gnt_pipe[RSP_LAT] : '0;
  assign bus.rsp_rdata_o = rdata_q;
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Randomized + directed bench for shared_dmem_arbiter against a cycle-level reference model.
module tb_shared_dmem_arbiter;
  localparam int P     = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  shared_dmem_arbiter_if #(.NUM_PORTS(P), .ADDR_W(AW), .DATA_W(DW)) bus();

  shared_dmem_arbiter #(.NUM_PORTS(P), .ADDR_W(AW), .DATA_W(DW), .DEPTH_WORDS(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester-side drive state
  logic          d_rst;
  bit            d_v  [P];
  bit            d_we [P];
  logic [AW-1:0] d_a  [P];
  logic [DW-1:0] d_d  [P];

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr;
  logic [P-1:0]  m_vld;
  logic [DW-1:0] m_rd  [P];
  bit            warm;

  task automatic cycle();
    int g;
    @(negedge clk_i);
    rst_i = d_rst;
    for (int p = 0; p < P; p++) begin
      bus.req_valid_i[p] = d_v[p];
      bus.req_we_i[p]    = d_we[p];
      bus.req_addr_i[p]  = d_a[p];
      bus.req_wdata_i[p] = d_d[p];
    end
    #2;
    g = -1;
    if (!d_rst)
      for (int k = 0; k < P; k++) begin
        int c;
        c = (m_ptr + k) % P;
        if (g < 0 && d_v[c]) g = c;
      end
    chk("ready", bus.req_ready_o, (g < 0) ? 0 : (1 << g));
    chk("rsp_valid", bus.rsp_valid_o, d_rst ? '0 : m_vld);
    if (warm)
      for (int p = 0; p < P; p++)
        chk($sformatf("rdata%0d", p), bus.rsp_rdata_o[p], m_rd[p]);
    if (d_rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int p = 0; p < P; p++) m_rd[p] = '0;
      m_ptr = 0;
      m_vld = '0;
      warm  = 1'b1;
    end else begin
      m_vld = '0;
      if (g >= 0) begin
        int i;
        i = int'((d_a[g] >> 2) % DEPTH);
        if (d_we[g]) m_mem[i] = d_d[g];
        else         m_rd[g]  = m_mem[i];
        m_vld[g] = 1'b1;
        m_ptr    = (g + 1) % P;
        d_v[g]   = 1'b0;
      end
    end
  endtask

  task automatic req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    d_v[p]  = 1'b1;
    d_we[p] = we;
    d_a[p]  = a;
    d_d[p]  = d;
  endtask

  // Run until every pending request is accepted, plus one cycle for the response.
  task automatic drain();
    int n;
    bit any;
    n   = 0;
    any = 1'b1;
    while (any && n < 50) begin
      any = 1'b0;
      for (int p = 0; p < P; p++) if (d_v[p]) any = 1'b1;
      if (any) begin
        cycle();
        n++;
      end
    end
    if (n >= 50) chk("drain_timeout", n, 0);
    cycle();
  endtask

  task automatic memclr();
    int nz;
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.memory[i] !== '0) nz++;
    chk("mem_clear", nz, 0);
  endtask

  task automatic do_reset(input int n);
    d_rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    d_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt [P];
    bit vb [P];
    rst_i           = 1'b1;
    bus.req_valid_i = '0;
    bus.req_we_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    m_ptr = 0;
    m_vld = '0;
    warm  = 1'b0;
    for (int p = 0; p < P; p++) begin
      req(p, 1'b0, AW'(p * 4), '0);
      wait_cnt[p] = 0;
    end

    // reset with all ports requesting
    do_reset(2);
    for (int p = 0; p < P; p++) d_v[p] = 1'b0;
    cycle();
    memclr();

    // single port write then read
    req(0, 1'b1, 32'h10, 32'h1234_5678);
    drain();
    req(0, 1'b0, 32'h10, '0);
    drain();
    chk("single_rd", bus.rsp_rdata_o[0], 32'h1234_5678);

    // contention: both ports read continuously, grants must alternate
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      req(0, 1'b0, 32'h10, '0);
      req(1, 1'b0, 32'h14, '0);
      cycle();
      chk("alternate", bus.req_ready_o, (k % 2 == 0) ? 1 : 2);
    end
    for (int p = 0; p < P; p++) d_v[p] = 1'b0;
    cycle();

    // same-address write/read in one cycle, ptr=0
    do_reset(1);
    req(0, 1'b1, 32'h20, 32'd5);
    req(1, 1'b0, 32'h20, '0);
    drain();
    chk("order_rd", bus.rsp_rdata_o[1], 32'd5);

    // address wrap and misaligned access
    req(0, 1'b1, AW'(DEPTH * 4 + 8), 32'hAA);
    drain();
    req(1, 1'b0, 32'd8, '0);
    drain();
    chk("wrap_rd", bus.rsp_rdata_o[1], 32'hAA);
    req(0, 1'b0, 32'd9, '0);
    drain();
    chk("misalign_rd", bus.rsp_rdata_o[0], 32'hAA);

    // reset the cycle after a read is accepted
    req(0, 1'b0, 32'h20, '0);
    cycle();
    d_rst = 1'b1;
    cycle();
    chk("midrst_vld", bus.rsp_valid_o, 0);
    d_rst = 1'b0;
    cycle();
    memclr();
    req(0, 1'b0, 32'h4, '0);
    req(1, 1'b0, 32'h8, '0);
    cycle();
    chk("ptr_after_rst", bus.req_ready_o, 1);
    drain();

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < P; p++)
        if (!d_v[p] && $urandom_range(0, 2) != 0)
          req(p, 1'($urandom_range(0, 1)),
              AW'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3) |
                  ($urandom_range(0, 1) != 0 ? DEPTH * 4 * $urandom_range(1, 5) : 0)),
              DW'($urandom));
      d_rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < P; p++) vb[p] = d_v[p];
      cycle();
      for (int p = 0; p < P; p++) begin
        if (d_rst) wait_cnt[p] = 0;
        else if (vb[p] && !bus.req_ready_o[p]) wait_cnt[p]++;
        else wait_cnt[p] = 0;
        if (wait_cnt[p] > P - 1) chk($sformatf("fair%0d", p), wait_cnt[p], P - 1);
      end
    end
    d_rst = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
